ppu_pool_relu: RTL and testbench
================================

PPU_POOL_RELU -- requirements
Module: ppu_pool_relu

Interface
REQ-001 The block SHALL have parameter ZP, default 8'd128, the activation zero point (the +128 offset applied by the post-quantization stage).
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of the output counter.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  upstream has a uint8 activation.
- in_ready  out  1  block can accept the activation this cycle.
- in_data  in  8  quantized activation, unsigned, zero point ZP.
- in_last  in  1  marks the final element of the tensor; qualified by in_valid.
- en_relu  in  1  apply ReLU about ZP.
- en_pool  in  1  apply 4-element max pooling; 0 = bypass.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8  pooled/ReLU'd activation.
- out_last  out  1  result closes the tensor.
- busy  out  1  a pooling window is partially filled.
- out_count  out  CNT_W  results delivered since reset.

Function
REQ-004 Transfer on a port SHALL occur only on a cycle where valid and ready are both 1 at the rising edge.
REQ-005 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-006 Once out_valid is 1, out_data and out_last SHALL remain stable until the transfer completes.
REQ-007 ReLU: v = en_relu ? max(in_data, ZP) : in_data, as an unsigned 8-bit compare.
REQ-008 Window counter cnt (2 bits) SHALL define the states: EMPTY (cnt=0) and FILLING (cnt=1..3).
REQ-009 en_relu and en_pool SHALL be sampled only on an accepted input with cnt=0 and held for the rest of the window; changes mid-window SHALL be ignored.
REQ-010 Bypass (latched en_pool=0): each accepted input SHALL load out_data=v and out_last=in_last, set out_valid on the next edge, and keep cnt=0.
REQ-011 Pool, accepted input with cnt=0: acc<=v, cnt<=1.
REQ-012 Pool, accepted input with cnt=1..2: acc<=max(acc,v), cnt<=cnt+1.
REQ-013 Pool, accepted input with cnt=3: out_data<=max(acc,v), out_valid<=1, out_last<=in_last, cnt<=0.
REQ-014 Pool, accepted input with in_last=1 at any cnt: emit max over the partial window including v, set out_last=1, cnt<=0 (flush).
REQ-015 Latency: result SHALL be visible on out_valid one cycle after the accepting edge of the window's closing element.
REQ-016 Throughput: with out_ready held 1, one input SHALL be accepted every cycle without bubbles.
REQ-017 Simultaneous output transfer and window-closing input SHALL load the new result and keep out_valid=1.
REQ-018 Output transfer with no new result: out_valid<=0.
REQ-019 busy SHALL equal (cnt!=0).
REQ-020 out_count SHALL increment by 1 per output transfer and wrap modulo 2^CNT_W.

Reset
REQ-021 rst=1 SHALL immediately clear cnt, acc, out_data, out_valid, out_last, out_count and the latched config to 0, independent of clk.
REQ-022 Reset asserted mid-window SHALL discard the partial window; no result SHALL be emitted for it after release.
REQ-023 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-024 Pool, relu off, out_ready=1, inputs 10,200,50,7 -> single out_data=200 one cycle after the 4th input; out_count=1.
REQ-025 Pool, relu on, inputs 3,90,127,20 -> out_data=128; bypass, relu on, input 100 -> 128, input 129 -> 129.
REQ-026 Pool, inputs 5,9 with in_last on 9 -> out_data=9, out_last=1, busy=0 afterward.
REQ-027 out_ready=0 for 5 cycles with result held -> out_data stable, in_ready=0, no input lost; release -> streaming resumes at 1/cycle.
REQ-028 rst pulsed after 2 of 4 inputs -> all outputs 0; next 4 inputs 1,2,3,4 -> out_data=4.
REQ-029 Toggle en_pool mid-window -> ignored until the window closes; 2^CNT_W transfers -> out_count wraps to 0.

Source files
------------

// File: rtl/ppu_pool_relu.sv
// Post-processing stage: optional ReLU about the zero point, then optional
// 4-element max pooling, behind a valid/ready stream with a one-deep output register.
module ppu_pool_relu #(
  parameter logic [7:0] ZP    = 8'd128,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             en_relu,
  input  logic             en_pool,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] out_count
);

  logic [1:0] cnt;
  logic [7:0] acc;
  logic       relu_q;
  logic       pool_q;

  logic       accept;
  logic       out_xfer;
  logic       relu_eff;
  logic       pool_eff;
  logic       close;
  logic [7:0] v;
  logic [7:0] mx;
  logic [7:0] result;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign busy     = (cnt != 2'd0);

  // The window's first element sees the live enables; later ones use the latched copy.
  assign relu_eff = (cnt == 2'd0) ? en_relu : relu_q;
  assign pool_eff = (cnt == 2'd0) ? en_pool : pool_q;

  assign v      = (relu_eff && (in_data < ZP)) ? ZP : in_data;
  assign mx     = (acc > v) ? acc : v;
  assign result = (pool_eff && (cnt != 2'd0)) ? mx : v;
  assign close  = accept && (!pool_eff || in_last || (cnt == 2'd3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 2'd0;
      acc       <= 8'd0;
      relu_q    <= 1'b0;
      pool_q    <= 1'b0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else begin
      if (accept && (cnt == 2'd0)) begin
        relu_q <= en_relu;
        pool_q <= en_pool;
      end

      if (accept && pool_eff) begin
        acc <= result;
      end

      if (close) begin
        cnt <= 2'd0;
      end else if (accept) begin
        cnt <= cnt + 2'd1;
      end

      // A closing input wins over a draining output so the register never bubbles.
      if (close) begin
        out_data  <= result;
        out_last  <= in_last;
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end

      if (out_xfer) begin
        out_count <= out_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_ppu_pool_relu.sv
// Scoreboard bench for ppu_pool_relu: a reference model pushes expected results
// as inputs are accepted; a negedge monitor pops and compares each output transfer.
module tb_ppu_pool_relu;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             en_relu;
  logic             en_pool;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] out_count;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } result_t;

  result_t sb[$];
  int      n_checks  = 0;
  int      n_pass    = 0;
  int      n_xfer    = 0;
  int      xfer_base = 0;
  int      cycle     = 0;

  logic [1:0] m_cnt;
  logic [7:0] m_acc;
  logic       m_relu;
  logic       m_pool;

  ppu_pool_relu #(.ZP(8'd128), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .en_relu  (en_relu),
    .en_pool  (en_pool),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Outputs are stable at the negedge; a transfer seen here completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [CNT_W-1:0] exp_cnt;
      result_t e;
      exp_cnt = CNT_W'(n_xfer - xfer_base);
      checkOutput("out_count", int'(out_count), int'(exp_cnt));
      checkOutput("sb_pending", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("out_data", int'(out_data), int'(e.data));
        checkOutput("out_last", int'(out_last), int'(e.last));
      end
      n_xfer <= n_xfer + 1;
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic last,
                               input logic relu, input logic pool);
    logic       rdy;
    logic       ok;
    logic [7:0] v;
    logic [7:0] a;
    in_data  = d;
    in_last  = last;
    en_relu  = relu;
    en_pool  = pool;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk) rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checkOutput("accepted", int'(ok), 1);
    if (ok) begin
      if (m_cnt == 2'd0) begin
        m_relu = relu;
        m_pool = pool;
      end
      v = (m_relu && d < 8'd128) ? 8'd128 : d;
      if (!m_pool) begin
        sb.push_back('{data: v, last: last});
      end else begin
        a = (m_cnt == 2'd0 || v > m_acc) ? v : m_acc;
        if (last || m_cnt == 2'd3) begin
          sb.push_back('{data: a, last: last});
          m_cnt = 2'd0;
        end else begin
          m_acc = a;
          m_cnt = m_cnt + 2'd1;
        end
      end
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drained", int'(done), 1);
  endtask

  initial begin
    int t0;
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    en_relu = 1'b0; en_pool = 1'b0; out_ready = 1'b1;
    m_cnt = 2'd0; m_acc = 8'd0; m_relu = 1'b0; m_pool = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_count", int'(out_count), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", int'(in_ready), 1);

    // Pool 10,200,50,7: result visible right after the 4th accepting edge.
    applyStimulus(8'd10, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd200, 1'b0, 1'b0, 1'b1);
    checkOutput("busy_mid_window", int'(busy), 1);
    applyStimulus(8'd50, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd7, 1'b0, 1'b0, 1'b1);
    checkOutput("latency_valid", int'(out_valid), 1);
    checkOutput("latency_data", int'(out_data), 200);
    drain();
    checkOutput("count_one", int'(out_count), 1);

    // ReLU clamps to the zero point, in pool and bypass modes.
    applyStimulus(8'd3, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'd90, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'd127, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'd20, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'd100, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd129, 1'b0, 1'b1, 1'b0);
    drain();

    // Partial window flushed by in_last.
    applyStimulus(8'd5, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd9, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_last", int'(out_last), 1);
    drain();
    checkOutput("flush_busy", int'(busy), 0);

    // Downstream stall: held result stays stable and the next input waits.
    out_ready = 1'b0;
    applyStimulus(8'd55, 1'b0, 1'b0, 1'b0);
    fork
      applyStimulus(8'd66, 1'b0, 1'b0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_data", int'(out_data), 55);
          checkOutput("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    // Back-to-back streaming at one input per cycle.
    t0 = cycle;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(i * 31 + 4), (i == 7), 1'b0, 1'b1);
    end
    checkOutput("throughput", cycle - t0, 8);
    drain();

    // Reset mid-window discards the partial window.
    applyStimulus(8'd250, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd240, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_data", int'(out_data), 0);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_count", int'(out_count), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    #1 rst = 1'b0;
    xfer_base = n_xfer;
    m_cnt = 2'd0;
    @(posedge clk);
    #1;
    applyStimulus(8'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd4, 1'b0, 1'b0, 1'b1);
    checkOutput("after_rst_data", int'(out_data), 4);
    drain();

    // Enables changed mid-window are ignored until the window closes.
    applyStimulus(8'd7, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd50, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd20, 1'b0, 1'b1, 1'b0);
    checkOutput("latched_cfg_data", int'(out_data), 50);
    drain();

    // Stream enough bypass results to wrap the output counter.
    k = (1 << CNT_W) - (n_xfer - xfer_base);
    for (int i = 0; i < k; i++) begin
      applyStimulus(8'(i), 1'b0, 1'b0, 1'b0);
    end
    drain();
    checkOutput("count_wrap", int'(out_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
